// File: rtl/inst_prefetch_pkg.sv
// Shared RiSC-16 constants and opcode encoding used by the prefetch unit and its bench.
package inst_prefetch_pkg;

  localparam int c_WORD_LEN = 16;
  localparam logic [c_WORD_LEN-1:0] c_NOP = 16'h0000;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_NAND = 3'd2,
    OP_LUI  = 3'd3,
    OP_SW   = 3'd4,
    OP_LW   = 3'd5,
    OP_BEQ  = 3'd6,
    OP_JALR = 3'd7
  } opcode_e;

  function automatic opcode_e decode_op(input logic [c_WORD_LEN-1:0] inst);
    return opcode_e'(inst[c_WORD_LEN-1 -: 3]);
  endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// Core fetch port and instruction-memory read port of the prefetch unit.
interface inst_prefetch_if
  import inst_prefetch_pkg::*;
#(
  parameter int p_WORD_LEN = c_WORD_LEN
);
  logic [p_WORD_LEN-1:0] i_pc_req;
  logic                  i_fetch_stall;
  logic [p_WORD_LEN-1:0] o_inst;
  logic                  o_inst_valid;
  logic [p_WORD_LEN-1:0] o_inst_pc;
  logic                  o_mem_req;
  logic [p_WORD_LEN-1:0] o_mem_addr;
  logic                  i_mem_gnt;
  logic                  i_mem_rvalid;
  logic [p_WORD_LEN-1:0] i_mem_rdata;

  modport master (
    input  i_pc_req, i_fetch_stall, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_inst, o_inst_valid, o_inst_pc, o_mem_req, o_mem_addr
  );

  modport slave (
    output i_pc_req, i_fetch_stall, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_inst, o_inst_valid, o_inst_pc, o_mem_req, o_mem_addr
  );
endinterface

// File: rtl/inst_prefetch_fifo.sv
// Small FIFO of {pc, inst} pairs; flush wins over push and pop.
module inst_prefetch_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int p_DEPTH    = 4,
  parameter int p_WORD_LEN = c_WORD_LEN
)(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [p_WORD_LEN-1:0]        wr_pc,
  input  logic [p_WORD_LEN-1:0]        wr_inst,
  output logic [p_WORD_LEN-1:0]        head_pc,
  output logic [p_WORD_LEN-1:0]        head_inst,
  output logic [$clog2(p_DEPTH):0]     count
);
  localparam int AW = $clog2(p_DEPTH);
  localparam logic [AW:0] c_FULL = (AW+1)'(p_DEPTH);

  logic [p_WORD_LEN-1:0] pc_mem   [p_DEPTH];
  logic [p_WORD_LEN-1:0] inst_mem [p_DEPTH];
  logic [AW-1:0]         rd_ptr, wr_ptr;
  logic                  do_push, do_pop;

  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count != c_FULL) || do_pop);

  // Storage carries no reset; the top masks head outputs while count is zero.
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      pc_mem[wr_ptr]   <= wr_pc;
      inst_mem[wr_ptr] <= wr_inst;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  assign head_pc   = pc_mem[rd_ptr];
  assign head_inst = inst_mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: issues reads ahead of the core, serves hits combinationally, restarts on redirect.
module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int p_DEPTH    = 4,
  parameter int p_WORD_LEN = c_WORD_LEN
)(
  input  logic          i_clk,
  input  logic          i_rst,
  inst_prefetch_if.master bus
);
  localparam int c_CW = $clog2(p_DEPTH) + 1;

  logic [p_WORD_LEN-1:0] r_fetch_pc, r_resp_pc;
  logic [p_WORD_LEN-1:0] head_pc, head_inst;
  logic [c_CW-1:0]       r_inflight, r_discard, count;
  logic                  buf_empty, hit, redirect, issue;
  logic                  gnt_fire, resp_fire, push, pop;

  assign buf_empty = (count == '0);
  assign hit       = !buf_empty && (head_pc == bus.i_pc_req);
  // With the buffer empty, the next word to land is tagged r_resp_pc, so that is the pc the core can still expect.
  assign redirect  = buf_empty ? (r_resp_pc != bus.i_pc_req) : (head_pc != bus.i_pc_req);
  assign issue     = !i_rst && !redirect &&
                     (({1'b0, count} + {1'b0, r_inflight}) < (c_CW+1)'(p_DEPTH));

  assign gnt_fire  = issue && bus.i_mem_gnt;
  assign resp_fire = bus.i_mem_rvalid && (r_inflight != '0);
  assign push      = resp_fire && !redirect && (r_discard == '0);
  assign pop       = hit && !bus.i_fetch_stall;

  assign bus.o_mem_req    = issue;
  assign bus.o_mem_addr   = r_fetch_pc;
  assign bus.o_inst_valid = hit;
  assign bus.o_inst       = hit ? head_inst : p_WORD_LEN'(c_NOP);
  assign bus.o_inst_pc    = buf_empty ? '0 : head_pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc <= '0;
      r_resp_pc  <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
    end else if (redirect) begin
      // Everything still outstanding belongs to the old stream, including a word landing right now.
      r_fetch_pc <= bus.i_pc_req;
      r_resp_pc  <= bus.i_pc_req;
      r_inflight <= r_inflight - c_CW'(resp_fire);
      r_discard  <= r_inflight - c_CW'(resp_fire);
    end else begin
      if (gnt_fire) r_fetch_pc <= r_fetch_pc + p_WORD_LEN'(1);
      r_inflight <= r_inflight + c_CW'(gnt_fire) - c_CW'(resp_fire);
      if (resp_fire) begin
        if (r_discard != '0) r_discard <= r_discard - c_CW'(1);
        else                 r_resp_pc <= r_resp_pc + p_WORD_LEN'(1);
      end
    end
  end

  inst_prefetch_fifo #(
    .p_DEPTH    (p_DEPTH),
    .p_WORD_LEN (p_WORD_LEN)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .wr_pc     (r_resp_pc),
    .wr_inst   (bus.i_mem_rdata),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .count     (count)
  );

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: vector table, directed multi-cycle sequences and random traffic against a PC-indexed memory.
module tb_inst_prefetch;
  import inst_prefetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  inst_prefetch_if #(.p_WORD_LEN(16)) bus ();

  inst_prefetch #(.p_DEPTH(DEPTH), .p_WORD_LEN(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference instruction memory and in-order response pipeline of the bench memory.
  logic [15:0] ref_mem [65536];
  typedef struct { logic [15:0] addr; int ready; } pend_t;
  pend_t       mq[$];
  logic [15:0] gnt_log[$];
  int          cyc, outstanding;
  logic        s_valid, s_req;
  logic [15:0] s_inst, s_ipc, s_addr;
  logic [15:0] core_pc;

  typedef struct {
    logic [15:0] pc; logic stall; logic gnt; logic rv; logic [15:0] rdata;
    logic ev; logic [15:0] einst; logic [15:0] eipc; logic ereq; logic [15:0] eaddr;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [15:0] pc, input logic st, input logic g, input logic rv,
                               input logic [15:0] rd, input logic ev, input logic [15:0] ei,
                               input logic [15:0] ep, input logic er, input logic [15:0] ea);
    vec_t v;
    v.pc = pc; v.stall = st; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.ev = ev; v.einst = ei; v.eipc = ep; v.ereq = er; v.eaddr = ea;
    return v;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (gnt_log.size() > i) ? 32'(gnt_log[i]) : 32'hDEAD_BEEF;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.i_pc_req = '0; bus.i_fetch_stall = 1'b0; bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b0; bus.i_mem_rdata = '0;
    @(negedge clk);
    chk("rst_inst_valid", bus.o_inst_valid, 1'b0);
    chk("rst_inst", bus.o_inst, 16'h0);
    chk("rst_inst_pc", bus.o_inst_pc, 16'h0);
    chk("rst_mem_req", bus.o_mem_req, 1'b0);
    chk("rst_mem_addr", bus.o_mem_addr, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); gnt_log.delete();
    outstanding = 0; cyc = 0; core_pc = '0;
  endtask

  // One clock cycle with the bench memory answering in order after `lat` cycles.
  task automatic tick(input logic [15:0] pc, input logic stall, input logic gnt_en,
                      input int lat, input logic stray);
    logic        rv;
    logic [15:0] rd;
    rv = 1'b0; rd = '0;
    if (stray) begin
      rv = 1'b1; rd = ~ref_mem[0];
    end else if (mq.size() > 0 && mq[0].ready <= cyc) begin
      rv = 1'b1; rd = ref_mem[mq[0].addr];
    end
    bus.i_pc_req = pc; bus.i_fetch_stall = stall;
    bus.i_mem_rvalid = rv; bus.i_mem_rdata = rd; bus.i_mem_gnt = 1'b0;
    @(negedge clk);
    s_valid = bus.o_inst_valid; s_inst = bus.o_inst; s_ipc = bus.o_inst_pc;
    s_req = bus.o_mem_req; s_addr = bus.o_mem_addr;
    bus.i_mem_gnt = gnt_en;
    if (s_valid) begin
      chk("inst_data", s_inst, ref_mem[pc]);
      chk("inst_pc", s_ipc, pc);
    end else begin
      chk("nop_inst", s_inst, c_NOP);
    end
    if (rv && !stray) chk("rvalid_with_outstanding", outstanding > 0, 1'b1);
    @(posedge clk); #1;
    if (rv && !stray) begin
      void'(mq.pop_front());
      outstanding--;
    end
    if (s_req && gnt_en) begin
      mq.push_back('{s_addr, cyc + lat});
      gnt_log.push_back(s_addr);
      outstanding++;
    end
    chk("outstanding_cap", outstanding <= DEPTH, 1'b1);
    cyc++;
  endtask

  task automatic core_step(input logic stall, input logic gnt_en, input int lat);
    tick(core_pc, stall, gnt_en, lat, 1'b0);
    if (s_valid && !stall) core_pc = core_pc + 16'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, served;
    logic st, g;
    int lat;

    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'(i) ^ 16'hA5A5;

    // Reset, sequential stream with 1-cycle memory, then full buffer under stall at pc 5.
    vt.push_back(mkv(16'd0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'd0, 1, 16'd0));
    vt.push_back(mkv(16'd0, 0, 1, 1, 16'hA5A5, 0, 16'h0000, 16'd0, 1, 16'd1));
    vt.push_back(mkv(16'd0, 0, 1, 1, 16'hA5A4, 1, 16'hA5A5, 16'd0, 1, 16'd2));
    vt.push_back(mkv(16'd1, 0, 1, 1, 16'hA5A7, 1, 16'hA5A4, 16'd1, 1, 16'd3));
    vt.push_back(mkv(16'd2, 0, 1, 1, 16'hA5A6, 1, 16'hA5A7, 16'd2, 1, 16'd4));
    vt.push_back(mkv(16'd3, 0, 1, 1, 16'hA5A1, 1, 16'hA5A6, 16'd3, 1, 16'd5));
    vt.push_back(mkv(16'd4, 0, 1, 1, 16'hA5A0, 1, 16'hA5A1, 16'd4, 1, 16'd6));
    vt.push_back(mkv(16'd5, 1, 1, 1, 16'hA5A3, 1, 16'hA5A0, 16'd5, 1, 16'd7));
    vt.push_back(mkv(16'd5, 1, 1, 1, 16'hA5A2, 1, 16'hA5A0, 16'd5, 1, 16'd8));
    vt.push_back(mkv(16'd5, 1, 0, 1, 16'hA5AD, 1, 16'hA5A0, 16'd5, 0, 16'd9));
    vt.push_back(mkv(16'd5, 1, 0, 0, 16'h0000, 1, 16'hA5A0, 16'd5, 0, 16'd9));
    vt.push_back(mkv(16'd5, 0, 0, 0, 16'h0000, 1, 16'hA5A0, 16'd5, 0, 16'd9));
    vt.push_back(mkv(16'd6, 0, 0, 0, 16'h0000, 1, 16'hA5A3, 16'd6, 1, 16'd9));
    vt.push_back(mkv(16'd7, 0, 0, 0, 16'h0000, 1, 16'hA5A2, 16'd7, 1, 16'd9));
    vt.push_back(mkv(16'd8, 0, 0, 0, 16'h0000, 1, 16'hA5AD, 16'd8, 1, 16'd9));
    vt.push_back(mkv(16'd9, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'd0, 1, 16'd9));

    do_reset();
    foreach (vt[i]) begin
      bus.i_pc_req = vt[i].pc; bus.i_fetch_stall = vt[i].stall; bus.i_mem_gnt = vt[i].gnt;
      bus.i_mem_rvalid = vt[i].rv; bus.i_mem_rdata = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), bus.o_inst_valid, vt[i].ev);
      chk($sformatf("vec%0d_inst", i), bus.o_inst, vt[i].einst);
      chk($sformatf("vec%0d_inst_pc", i), bus.o_inst_pc, vt[i].eipc);
      chk($sformatf("vec%0d_mem_req", i), bus.o_mem_req, vt[i].ereq);
      chk($sformatf("vec%0d_mem_addr", i), bus.o_mem_addr, vt[i].eaddr);
      @(posedge clk); #1;
    end

    // Redirect from pc 6 to 0x0040 with two requests in flight, memory latency 3.
    do_reset();
    for (int k = 0; k < 60 && core_pc != 16'd6; k++) core_step(1'b0, 1'b1, 3);
    chk("lat3_reach_pc6", core_pc, 16'd6);
    core_step(1'b1, 1'b1, 3);
    chk("lat3_inflight_at_redirect", outstanding, 2);
    gnt_log.delete();
    core_pc = 16'h0040;
    core_step(1'b0, 1'b1, 3);
    chk("lat3_redirect_no_req", s_req, 1'b0);
    first = -1;
    for (int j = 1; j <= 12 && first < 0; j++) begin
      core_step(1'b0, 1'b1, 3);
      if (s_valid) begin
        first = j;
        chk("lat3_first_inst_pc", s_ipc, 16'h0040);
      end
    end
    chk("lat3_redirect_penalty", first, 5);
    chk("lat3_first_req_addr", log_at(0), 16'h0040);

    // Wrap-around from 0xFFFE after a redirect with 1-cycle memory.
    do_reset();
    for (int k = 0; k < 6; k++) core_step(1'b0, 1'b1, 1);
    gnt_log.delete();
    core_pc = 16'hFFFE;
    core_step(1'b0, 1'b1, 1);
    chk("wrap_redirect_no_req", s_req, 1'b0);
    first = -1;
    for (int j = 1; j <= 10 && first < 0; j++) begin
      core_step(1'b0, 1'b1, 1);
      if (s_valid) first = j;
    end
    chk("wrap_redirect_penalty", first, 3);
    for (int k = 0; k < 3; k++) core_step(1'b0, 1'b1, 1);
    chk("wrap_served_through", core_pc, 16'h0002);
    chk("wrap_req0", log_at(0), 16'hFFFE);
    chk("wrap_req1", log_at(1), 16'hFFFF);
    chk("wrap_req2", log_at(2), 16'h0000);

    // Reset with two requests in flight, then a stray response right after release.
    do_reset();
    core_step(1'b0, 1'b1, 3);
    core_step(1'b0, 1'b1, 3);
    chk("midrst_outstanding", outstanding, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_inst_valid", bus.o_inst_valid, 1'b0);
    chk("midrst_inst", bus.o_inst, 16'h0);
    chk("midrst_inst_pc", bus.o_inst_pc, 16'h0);
    chk("midrst_mem_req", bus.o_mem_req, 1'b0);
    chk("midrst_mem_addr", bus.o_mem_addr, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); gnt_log.delete();
    outstanding = 0; cyc = 0; core_pc = '0;
    tick(16'h0000, 1'b0, 1'b0, 1, 1'b1);
    chk("postrst_req", s_req, 1'b1);
    chk("postrst_addr", s_addr, 16'h0000);
    first = -1;
    for (int j = 1; j <= 8 && first < 0; j++) begin
      core_step(1'b0, 1'b1, 1);
      if (s_valid) first = j;
    end
    chk("postrst_first_valid", first, 3);

    // Random grants, latencies, stalls and redirects against random memory contents.
    for (int i = 0; i < 65536; i++) ref_mem[i] = 16'($urandom);
    do_reset();
    served = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(31) == 0)
        core_pc = ($urandom_range(3) == 0) ? 16'hFFF0 + 16'($urandom_range(15)) : 16'($urandom);
      st  = ($urandom_range(4) == 0);
      g   = ($urandom_range(3) != 0);
      lat = 1 + $urandom_range(3);
      core_step(st, g, lat);
      if (s_valid && !st) served++;
    end
    chk("random_progress", served > 1000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
